// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared constants and types for the CNN datapath. Holds the layer-3 pooled
// feature-map geometry (12x12 bytes after 2x2 max-pooling), the bank-local
// and bank-qualified address widths used by the layer-4 ping-pong buffer,
// and the bank-state encoding used when describing buffer occupancy.
package cnn_pkg;

  // Sample width of every feature-map element.
  localparam int DATA_W = 8;

  // Geometry of the pooled layer-3 output map.
  localparam int POOL3_MAP_W     = 12;
  localparam int POOL3_MAP_H     = 12;
  localparam int POOL3_MAP_DEPTH = POOL3_MAP_W * POOL3_MAP_H;

  // Bank-local index width and full {bank, index} width.
  localparam int POOL3_ADDR_W = 8;
  localparam int BANK_ADDR_W  = POOL3_ADDR_W + 1;

  // Occupancy view of a single bank. READING is a FULL bank that the read
  // side is currently pointing at.
  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  // Derive a bank's state from its full flag and whether the write or read
  // pointer currently selects it.
  function automatic bank_state_e bank_state(input logic full,
                                             input logic is_wr_bank,
                                             input logic is_rd_bank);
    bank_state_e st;
    if (full) begin
      st = is_rd_bank ? BANK_READING : BANK_FULL;
    end else begin
      st = is_wr_bank ? BANK_FILLING : BANK_EMPTY;
    end
    return st;
  endfunction

endpackage

// File: rtl/pool_buf_ram.sv
// pool_buf_ram
// Simple dual-port storage for the two ping-pong banks of the layer-4 pool
// buffer: 2 banks x DEPTH entries x DATA_W bits.
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset (read
//                         register only; memory contents are never cleared)
//   we_i, wr_addr_i,      synchronous write port, address {bank, index}
//   wr_data_i
//   re_i, rd_addr_i       synchronous read port, address {bank, index}
//   rd_data_o             registered read data, held while re_i is low
module pool_buf_ram
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DEPTH  = cnn_pkg::POOL3_MAP_DEPTH,
  parameter int IDX_W  = cnn_pkg::POOL3_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W:0]    wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              re_i,
  input  logic [IDX_W:0]    rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [0:1][0:DEPTH-1];
  logic [DATA_W-1:0] rd_data_q;

  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_bank;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;

  assign wr_bank     = wr_addr_i[IDX_W];
  assign wr_idx      = wr_addr_i[IDX_W-1:0];
  assign rd_bank     = rd_addr_i[IDX_W];
  assign rd_idx      = rd_addr_i[IDX_W-1:0];
  // Indices past the end of a bank read back as zero rather than aliasing.
  assign rd_in_range = (rd_idx < IDX_W'(DEPTH));

  // Write port: no reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i && (wr_idx < IDX_W'(DEPTH))) begin
      mem[wr_bank][wr_idx] <= wr_data_i;
    end
  end

  // Registered read port; the output register is the only resettable state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (re_i) begin
      rd_data_q <= rd_in_range ? mem[rd_bank][rd_idx] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/layer_4_pool_buffer.sv
// layer_4_pool_buffer
// Ping-pong buffer between the layer-3 ReLU/max-pool stage and the layer-4
// convolution. Pooled bytes arrive one per rising edge of relu_3_ready and
// fill a 144-entry bank in row-major order; a completed bank is handed to
// layer 4 for random-access reads until layer 4 releases it with rd_done.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   d_in, relu_3_ready       pooled sample and its strobe from layer 3
//   rd_en, rd_addr           layer-4 read request, bank-local row*12+col
//   rd_done                  pulse releasing the bank currently being read
//   rd_data                  read data, one cycle after rd_en
//   layer_4_ready            a full bank is available at the read side
//   layer_4_write_complete   one-cycle pulse per completed bank
//   overflow                 sticky flag, a sample was dropped
module layer_4_pool_buffer #(
  parameter int DATA_W    = cnn_pkg::DATA_W,
  parameter int MAP_W     = cnn_pkg::POOL3_MAP_W,
  parameter int MAP_H     = cnn_pkg::POOL3_MAP_H,
  parameter int MAP_DEPTH = MAP_W * MAP_H,
  parameter int ADDR_W    = cnn_pkg::POOL3_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_in,
  input  logic              relu_3_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              layer_4_ready,
  output logic              layer_4_write_complete,
  output logic              overflow
);

  import cnn_pkg::*;

  logic              relu_prev_q;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  logic              overflow_q, overflow_d;
  logic              wr_done_q, wr_done_d;

  logic accept;
  logic wr_en;
  logic wr_last;
  logic rd_release;

  // A held strobe counts once: only its 0->1 transition accepts a sample.
  assign accept     = relu_3_ready & ~relu_prev_q;
  // Samples landing on a bank that is still full are dropped, never queued.
  assign wr_en      = accept & ~full_q[wr_bank_q];
  assign wr_last    = (wr_cnt_q == ADDR_W'(MAP_DEPTH - 1));
  // A release is only honoured while the read bank actually holds a frame.
  assign rd_release = rd_done & full_q[rd_bank_q];

  // Next-state logic. The write side only ever sets the flag of the bank it
  // is filling and the read side only clears the flag of the bank it is
  // reading; those are always different banks, so both can act together.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_cnt_d   = wr_cnt_q;
    full_d     = full_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow_q;
    wr_done_d  = 1'b0;

    if (wr_en) begin
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
        wr_done_d         = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (accept && full_q[wr_bank_q]) begin
      overflow_d = 1'b1;
    end

    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // State registers with synchronous reset; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      relu_prev_q <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      full_q      <= 2'b00;
      rd_bank_q   <= 1'b0;
      overflow_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      relu_prev_q <= relu_3_ready;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      overflow_q  <= overflow_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign layer_4_ready          = full_q[rd_bank_q];
  assign layer_4_write_complete = wr_done_q;
  assign overflow               = overflow_q;

  pool_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAP_DEPTH),
    .IDX_W  (ADDR_W)
  ) u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (wr_en),
    .wr_addr_i ({wr_bank_q, wr_cnt_q}),
    .wr_data_i (d_in),
    .re_i      (rd_en),
    .rd_addr_i ({rd_bank_q, rd_addr}),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_layer_4_pool_buffer.sv
// tb_layer_4_pool_buffer
// Directed-plus-random bench for the layer-4 ping-pong pool buffer. A
// frame-level reference model (a queue of completed 144-byte frames plus the
// frame under construction) predicts readiness, completion pulses, overflow
// and read data, and every cycle's outputs are compared against it.
module tb_layer_4_pool_buffer;

  localparam int DEPTH = 144;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_in;
  logic       relu_3_ready;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       rd_done;
  logic [7:0] rd_data;
  logic       layer_4_ready;
  logic       layer_4_write_complete;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: completed frames oldest first, the frame being
  // assembled, and the expected values of the registered outputs.
  logic [DEPTH*8-1:0] frames[$];
  logic [DEPTH*8-1:0] curFrame;
  int                 curCount;
  bit                 prevStrobe;
  bit                 expOverflow;
  bit                 expComplete;
  logic [7:0]         expRdData;
  bit                 expRdValid;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  layer_4_pool_buffer dut (
    .clk                    (clk),
    .rst                    (rst),
    .d_in                   (d_in),
    .relu_3_ready           (relu_3_ready),
    .rd_en                  (rd_en),
    .rd_addr                (rd_addr),
    .rd_done                (rd_done),
    .rd_data                (rd_data),
    .layer_4_ready          (layer_4_ready),
    .layer_4_write_complete (layer_4_write_complete),
    .overflow               (overflow)
  );

  // One comparison: counts it, and counts and reports it when it differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance the frame-level model by one clock edge using the inputs that
  // the DUT will sample at that edge.
  task automatic modelEdge(input logic strobe, input logic [7:0] din,
                           input logic ren, input logic [7:0] raddr,
                           input logic done);
    bit                 acc;
    bit                 readyBefore;
    logic [DEPTH*8-1:0] oldest;
    readyBefore = (frames.size() > 0);
    acc         = strobe && !prevStrobe;
    prevStrobe  = strobe;
    expComplete = 1'b0;

    if (ren) begin
      if (int'(raddr) >= DEPTH) begin
        expRdData  = 8'h00;
        expRdValid = 1'b1;
      end else if (readyBefore) begin
        oldest     = frames[0];
        expRdData  = oldest[int'(raddr)*8 +: 8];
        expRdValid = 1'b1;
      end else begin
        expRdValid = 1'b0;
      end
    end

    if (acc) begin
      if (frames.size() == 2) begin
        expOverflow = 1'b1;
      end else begin
        curFrame[curCount*8 +: 8] = din;
        curCount++;
        if (curCount == DEPTH) begin
          frames.push_back(curFrame);
          curCount    = 0;
          expComplete = 1'b1;
        end
      end
    end

    if (done && readyBefore) begin
      void'(frames.pop_front());
    end
  endtask

  // Compare every observable output against the model.
  task automatic checkAll(input string phase);
    checkOutput({phase, ".ready"}, 32'(layer_4_ready), 32'(frames.size() > 0));
    checkOutput({phase, ".complete"}, 32'(layer_4_write_complete), 32'(expComplete));
    checkOutput({phase, ".overflow"}, 32'(overflow), 32'(expOverflow));
    if (expRdValid) begin
      checkOutput({phase, ".rd_data"}, 32'(rd_data), 32'(expRdData));
    end
  endtask

  // Drive one cycle of inputs, step the model, and check just after the edge.
  task automatic applyStimulus(input string phase, input logic strobe,
                               input logic [7:0] din, input logic ren,
                               input logic [7:0] raddr, input logic done);
    relu_3_ready = strobe;
    d_in         = din;
    rd_en        = ren;
    rd_addr      = raddr;
    rd_done      = done;
    modelEdge(strobe, din, ren, raddr, done);
    @(posedge clk);
    #1;
    checkAll(phase);
  endtask

  // One sample: strobe high then low, with random reads riding along.
  task automatic sendSample(input string phase, input logic [7:0] din);
    applyStimulus(phase, 1'b1, din, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 159)), 1'b0);
    applyStimulus(phase, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 159)), 1'b0);
  endtask

  // Directed read followed by an idle cycle to confirm the data holds.
  task automatic readAt(input string phase, input logic [7:0] addr);
    applyStimulus(phase, 1'b0, 8'h00, 1'b1, addr, 1'b0);
    applyStimulus(phase, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  // Hold reset for two edges; every output must then read zero.
  task automatic doReset(input string phase);
    rst          = 1'b1;
    relu_3_ready = 1'b0;
    d_in         = 8'h00;
    rd_en        = 1'b0;
    rd_addr      = 8'h00;
    rd_done      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    frames.delete();
    curCount    = 0;
    prevStrobe  = 1'b0;
    expOverflow = 1'b0;
    expComplete = 1'b0;
    expRdData   = 8'h00;
    expRdValid  = 1'b1;
    checkOutput({phase, ".rst_ready"}, 32'(layer_4_ready), 32'd0);
    checkOutput({phase, ".rst_complete"}, 32'(layer_4_write_complete), 32'd0);
    checkOutput({phase, ".rst_overflow"}, 32'(overflow), 32'd0);
    checkOutput({phase, ".rst_rd_data"}, 32'(rd_data), 32'd0);
    rst = 1'b0;
  endtask

  // Linear sequence of directed scenarios followed by a random soak.
  initial begin
    rst          = 1'b1;
    relu_3_ready = 1'b0;
    d_in         = 8'h00;
    rd_en        = 1'b0;
    rd_addr      = 8'h00;
    rd_done      = 1'b0;
    curFrame     = '0;

    doReset("reset");

    // First frame: sample value equals its index.
    for (int i = 0; i < DEPTH; i++) sendSample("fill", 8'(i));
    readAt("fill_rd0", 8'd0);
    readAt("fill_rd13", 8'd13);
    readAt("fill_rd143", 8'd143);

    // Held strobe: five cycles high must store a single sample.
    for (int i = 0; i < 5; i++) applyStimulus("held", 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
    applyStimulus("held", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Rest of the second frame (values +100) while bank 0 is read randomly.
    for (int i = 1; i < DEPTH; i++) sendSample("pingpong", 8'(i + 100));
    applyStimulus("pingpong_done", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    readAt("pingpong_rd5", 8'd5);

    // Fill the other bank, then three strobes with both banks full.
    for (int i = 0; i < DEPTH; i++) sendSample("ovf_fill", 8'($urandom));
    for (int i = 0; i < 3; i++) sendSample("ovf_drop", 8'($urandom));
    readAt("ovf_rd0", 8'd0);

    // Release one bank, then complete a frame on the same edge as rd_done.
    applyStimulus("simul_rel", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) sendSample("simul_fill", 8'($urandom));
    applyStimulus("simul_last", 1'b1, 8'($urandom), 1'b0, 8'h00, 1'b1);
    applyStimulus("simul_last", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    readAt("simul_rd7", 8'd7);

    // Both full again, then a strobe on the releasing edge is still dropped.
    for (int i = 0; i < DEPTH; i++) sendSample("dropsame_fill", 8'($urandom));
    applyStimulus("dropsame", 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    applyStimulus("dropsame", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) sendSample("dropsame_next", 8'($urandom));
    readAt("dropsame_rd0", 8'd0);

    // Random soak over strobes, releases and reads.
    for (int i = 0; i < 600; i++) begin
      applyStimulus("random", 1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 159)),
                    ($urandom_range(0, 15) == 0));
    end

    // Reset mid-frame, then a complete frame lands in bank 0 again.
    doReset("midreset_a");
    for (int i = 0; i < 70; i++) sendSample("midframe", 8'($urandom));
    doReset("midreset_b");
    for (int i = 0; i < DEPTH; i++) sendSample("refill", 8'(255 - i));
    readAt("refill_rd200", 8'd200);
    for (int i = 0; i < 4; i++) readAt("refill_rd", 8'($urandom_range(0, 143)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/layer_4_pool_buffer.md
# layer_4_pool_buffer

Ping-pong feature-map buffer directly downstream of the layer-3 ReLU/2×2 max-pool stage. It captures the pooled 12×12 byte stream (one byte per `relu_3_ready` strobe, row-major) into one of two 144-byte banks. It hands each completed bank to the layer-4 convolution through a random-access read port with an explicit release handshake. Double buffering lets layer 3 pool the next frame while layer 4 reads the previous one.

## Interface
Parameters:
- `DATA_W`, 8, sample width
- `MAP_W`, 12, pooled map width
- `MAP_H`, 12, pooled map height
- `MAP_DEPTH`, 144, `MAP_W*MAP_H`, entries per bank
- `ADDR_W`, 8, bank-local address width

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `d_in` in `DATA_W`: pooled sample from layer 3 (`d_out` of the pool stage)
- `relu_3_ready` in 1: sample strobe from layer 3
- `rd_en` in 1: layer-4 read request
- `rd_addr` in `ADDR_W`: bank-local read address, row*12+col
- `rd_done` in 1: one-cycle pulse, layer 4 releases the current read bank
- `rd_data` out `DATA_W`: read data
- `layer_4_ready` out 1: a full bank is available for reading
- `layer_4_write_complete` out 1: one-cycle pulse per completed bank
- `overflow` out 1: sticky, sample dropped because both banks are full

## Operation
- Sample acceptance:
  - A sample is accepted on the rising edge of `relu_3_ready`, i.e. `relu_3_ready`=1 and its registered previous value is 0.
  - A strobe held high for N cycles counts once.
- Write side:
  - Registers: `wr_bank` (1 bit) and `wr_cnt` (0..143).
  - An accepted sample with `full[wr_bank]`=0 is written to {`wr_bank`,`wr_cnt`}.
  - On `wr_cnt`=143: set `full[wr_bank]`, `wr_cnt`←0, `wr_bank`←~`wr_bank`, pulse `layer_4_write_complete` next cycle.
  - Otherwise `wr_cnt`++.
- Drop rule: an accepted sample with `full[wr_bank]`=1 is dropped. `overflow`←1 and stays set until `rst`. `wr_cnt` is unchanged.
- Read side:
  - Register `rd_bank`; `layer_4_ready` = `full[rd_bank]`.
  - `rd_done` while `layer_4_ready`=1: clear `full[rd_bank]`, `rd_bank`←~`rd_bank`.
  - `rd_done` while `layer_4_ready`=0 is ignored.
- Bank order: banks fill and drain in alternating order, so `rd_bank` always points at the oldest full bank.
- Reads:
  - `rd_en`=1 returns mem[{`rd_bank`,`rd_addr`}].
  - `rd_addr`≥144 returns 0.
  - Reads are not gated by `layer_4_ready`; data from an unfilled bank is undefined.
- Per-bank state: EMPTY (`full`=0, not `wr_bank`), FILLING (`full`=0, = `wr_bank`), FULL (`full`=1). The read-side view of a FULL bank is READING when it equals `rd_bank`.
- Simultaneous events:
  - Final write (set `full[b]`) and `rd_done` releasing bank ~b in the same cycle: both take effect.
  - A sample dropped in that same cycle (`full[wr_bank]` seen as 1 before the release) stays dropped. No look-ahead.
- Reset (also mid-frame): `full`=00, `wr_bank`=0, `rd_bank`=0, `wr_cnt`=0, edge register=0, `rd_data`=0, `layer_4_ready`=0, `layer_4_write_complete`=0, `overflow`=0. Memory contents are not cleared.

## Timing
- Read latency 1: `rd_en` and `rd_addr` sampled at edge k, `rd_data` valid after edge k, held until the next `rd_en` cycle.
- Write: the sample is in RAM after the accepting edge. A read of the same location in the following cycle returns the new value.
- `layer_4_write_complete` is high exactly 1 cycle, the cycle after the 144th accepting edge. `layer_4_ready` rises in the same cycle when that bank is `rd_bank`.
- `layer_4_ready` falls 1 cycle after the `rd_done` edge, or stays 1 if the other bank is already full.
- Throughput: one sample per 2 cycles minimum, since a strobe needs a 0 between samples. This is sufficient for the 3-cycle pool cadence.

## Structure
- Shared package `cnn_pkg`: `DATA_W`, `POOL3_MAP_W`/`H`/`DEPTH`, bank-address width, bank-state encoding constants.
- One sub-module `pool_buf_ram`:
  - simple dual-port, 2×144×8 bits
  - one synchronous write port, one synchronous registered read port
  - 9-bit address {bank, idx}
  - infers block RAM
- The top level holds the edge detector, write counter, bank flags and read control.

## Test plan
- Fill: 144 strobes with `d_in`=index mod 256 → `layer_4_write_complete` pulses once, `layer_4_ready`=1; reading addr 0, 13, 143 returns 0, 13, 143 one cycle later.
- Held strobe: `relu_3_ready` high 5 cycles with `d_in`=0xAA → exactly one write, `wr_cnt`=1, no overflow.
- Ping-pong: fill bank 0, then stream a second frame (values +100) while reading bank 0; `rd_done` → `layer_4_ready` stays 1 and addr 5 reads 105.
- Overflow: fill both banks without `rd_done`, send 3 more strobes → `overflow`=1, bank 0 addr 0 still reads 0, `wr_cnt` stays 0.
- Simultaneous: 144th sample of bank 1 coincides with `rd_done` of bank 0 → `full`=10, `rd_bank`=1, `layer_4_ready`=1 continuously.
- Reset mid-frame after 70 samples → all outputs 0; next 144 strobes complete bank 0 with a single `layer_4_write_complete`; `rd_addr`=200 reads 0.
